// File: rtl/sdram_pkg.sv
// ============================================================================
// sdram_pkg: SDRAM command encodings, mode-register fields and timing minimums
// Rev 1.0
// ============================================================================
`default_nettype none

package sdram_pkg;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_LOAD_MODE    = 3'b000,
    CMD_AUTO_REFRESH = 3'b001,
    CMD_PRECHARGE    = 3'b010,
    CMD_ACTIVE       = 3'b011,
    CMD_WRITE        = 3'b100,
    CMD_READ         = 3'b101,
    CMD_BURST_TERM   = 3'b110,
    CMD_NOP          = 3'b111
  } sdram_cmd_e;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_W   = 3;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_W   = 3;
  localparam int ADDR_AP_BIT = 10;

  // BL code n selects a burst of 2**n words
  localparam logic [2:0] BL_CODE_MAX   = 3'd3;
  localparam logic [1:0] BL_CODE_RESET = 2'd3;
  localparam logic [2:0] CL_CODE_2     = 3'd2;
  localparam logic [2:0] CL_CODE_3     = 3'd3;

  localparam int         TIMER_W = 3;
  localparam logic [2:0] T_RCD   = 3'd2;
  localparam logic [2:0] T_RP    = 3'd2;
  localparam logic [2:0] T_RC    = 3'd7;

endpackage

`default_nettype wire

// File: rtl/sdram_bank_state.sv
// ============================================================================
// sdram_bank_state: open flag, open row and auto-precharge state for one bank
// Optional timing counters under SDRAM_TIMING_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sdram_bank_state
  import sdram_pkg::*;
#(
  parameter int RowAddrLen = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_clk_en,
  input  logic                  i_activate,
  input  logic                  i_precharge,
  input  logic                  i_ap_req,
  input  logic [RowAddrLen-1:0] i_row,
`ifdef SDRAM_TIMING_CHECK_EN
  input  logic                  i_refresh,
  output logic                  o_rcd_ok,
  output logic                  o_rp_ok,
  output logic                  o_rc_ok,
`endif
  output logic                  o_open,
  output logic [RowAddrLen-1:0] o_row
);

  logic r_ap_pend;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_open    <= 1'b0;
      o_row     <= '0;
      r_ap_pend <= 1'b0;
    end else if (i_clk_en) begin
      // A pending auto-precharge closes the bank one edge after the last word
      if (i_precharge || r_ap_pend) begin
        o_open    <= 1'b0;
        r_ap_pend <= 1'b0;
      end else begin
        if (i_activate) begin
          o_open <= 1'b1;
          o_row  <= i_row;
        end
        if (i_ap_req) r_ap_pend <= 1'b1;
      end
    end
  end

`ifdef SDRAM_TIMING_CHECK_EN
  // Counters hold the number of edges since the event, saturating at all-ones
  logic [TIMER_W-1:0] r_rcd_cnt, r_rp_cnt, r_rc_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rcd_cnt <= '1;
      r_rp_cnt  <= '1;
      r_rc_cnt  <= '1;
    end else if (i_clk_en) begin
      r_rcd_cnt <= i_activate  ? TIMER_W'(1) : (&r_rcd_cnt ? r_rcd_cnt : r_rcd_cnt + 1'b1);
      r_rp_cnt  <= i_precharge ? TIMER_W'(1) : (&r_rp_cnt  ? r_rp_cnt  : r_rp_cnt  + 1'b1);
      r_rc_cnt  <= i_refresh   ? TIMER_W'(1) : (&r_rc_cnt  ? r_rc_cnt  : r_rc_cnt  + 1'b1);
    end
  end

  assign o_rcd_ok = (r_rcd_cnt >= T_RCD);
  assign o_rp_ok  = (r_rp_cnt  >= T_RP);
  assign o_rc_ok  = (r_rc_cnt  >= T_RC);
`endif

endmodule

`default_nettype wire

// File: rtl/sdram_device_model.sv
// ============================================================================
// sdram_device_model: cycle-accurate SDR SDRAM device responder with array.
// Optional tRCD/tRP/tRC checking under SDRAM_TIMING_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sdram_device_model
  import sdram_pkg::*;
#(
  parameter int WordLength   = 16,
  parameter int BankAddrLen  = 2,
  parameter int RowAddrLen   = 13,
  parameter int ColAddrLen   = 9,
  parameter int MemAddrWidth = 12
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_clk_en,
  input  logic                      i_cs_n,
  input  logic                      i_ras_n,
  input  logic                      i_cas_n,
  input  logic                      i_we_n,
  input  logic [RowAddrLen-1:0]     i_addr,
  input  logic [BankAddrLen-1:0]    i_bank,
  input  logic [WordLength/8-1:0]   i_dqm,
  input  logic [WordLength-1:0]     i_dq,
  output logic [WordLength-1:0]     o_dq,
  output logic                      o_dq_oe,
  output logic                      o_proto_err,
  output logic [2**BankAddrLen-1:0] o_open_banks
);

  localparam int NUM_BANKS   = 2**BankAddrLen;
  localparam int NUM_BYTES   = WordLength/8;
  localparam int MEM_DEPTH   = 2**MemAddrWidth;
  localparam int FULL_ADDR_W = BankAddrLen + RowAddrLen + ColAddrLen;

  sdram_cmd_e              w_cmd;
  logic [NUM_BANKS-1:0]    w_open, w_act, w_pre, w_ap_req;
  logic [RowAddrLen-1:0]   w_bank_row [NUM_BANKS];
  logic                    w_is_rw, w_sel_open, w_rw_ok, w_pre_all, w_abort;
  logic                    w_mode_bad, w_proto_err, w_timing_err;
  logic [MODE_BL_W-1:0]    w_mode_bl;
  logic [MODE_CL_W-1:0]    w_mode_cl;
  logic [2:0]              w_bl_mask;

  logic [1:0]              r_bl_code;
  logic                    r_cl3;
  logic                    r_bst_active, r_bst_wr, r_bst_ap;
  logic [BankAddrLen-1:0]  r_bst_bank;
  logic [RowAddrLen-1:0]   r_bst_row;
  logic [ColAddrLen-1:0]   r_bst_base;
  logic [2:0]              r_bst_idx;
  logic                    r_p1_v, r_p2_v;
  logic [WordLength-1:0]   r_p1_d, r_p2_d;
  logic [WordLength-1:0]   r_mem [MEM_DEPTH];

  logic                    w_iss, w_iss_wr, w_iss_ap, w_iss_last, w_out_v;
  logic [BankAddrLen-1:0]  w_iss_bank;
  logic [RowAddrLen-1:0]   w_iss_row;
  logic [ColAddrLen-1:0]   w_iss_base, w_iss_col, w_col_mask;
  logic [2:0]              w_iss_k;
  logic [FULL_ADDR_W-1:0]  w_full_addr;
  logic [MemAddrWidth-1:0] w_mem_idx;
  logic [WordLength-1:0]   w_out_d;

  assign w_cmd       = i_cs_n ? CMD_NOP : sdram_cmd_e'({i_ras_n, i_cas_n, i_we_n});
  assign w_is_rw     = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE);
  assign w_sel_open  = w_open[i_bank];
  assign w_rw_ok     = w_is_rw && w_sel_open;
  assign w_pre_all   = i_addr[ADDR_AP_BIT];
  assign w_mode_bl   = i_addr[MODE_BL_LSB +: MODE_BL_W];
  assign w_mode_cl   = i_addr[MODE_CL_LSB +: MODE_CL_W];
  assign w_mode_bad  = (w_mode_bl > BL_CODE_MAX) ||
                       !((w_mode_cl == CL_CODE_2) || (w_mode_cl == CL_CODE_3));
  assign w_proto_err = (w_is_rw && !w_sel_open) ||
                       ((w_cmd == CMD_ACTIVE) && w_sel_open) ||
                       ((w_cmd == CMD_LOAD_MODE) && (|w_open || w_mode_bad)) ||
                       ((w_cmd == CMD_AUTO_REFRESH) && |w_open);
  assign w_abort     = (w_cmd == CMD_BURST_TERM) ||
                       ((w_cmd == CMD_PRECHARGE) && (w_pre_all || (i_bank == r_bst_bank)));
  assign w_bl_mask   = 3'((4'd1 << r_bl_code) - 4'd1);
  assign o_open_banks = w_open;

  // A legal READ/WRITE issues word 0 itself; otherwise a running burst issues its next word
  always_comb begin
    w_iss      = 1'b0;
    w_iss_wr   = (w_cmd == CMD_WRITE);
    w_iss_ap   = i_addr[ADDR_AP_BIT];
    w_iss_bank = i_bank;
    w_iss_row  = w_bank_row[i_bank];
    w_iss_base = i_addr[ColAddrLen-1:0];
    w_iss_k    = 3'd0;
    if (w_rw_ok) begin
      w_iss = 1'b1;
    end else if (r_bst_active && !w_abort) begin
      w_iss      = 1'b1;
      w_iss_wr   = r_bst_wr;
      w_iss_ap   = r_bst_ap;
      w_iss_bank = r_bst_bank;
      w_iss_row  = r_bst_row;
      w_iss_base = r_bst_base;
      w_iss_k    = r_bst_idx;
    end
  end

  assign w_iss_last  = (w_iss_k == w_bl_mask);
  assign w_col_mask  = ColAddrLen'(w_bl_mask);
  assign w_iss_col   = (w_iss_base & ~w_col_mask) |
                       ((w_iss_base + ColAddrLen'(w_iss_k)) & w_col_mask);
  assign w_full_addr = {w_iss_bank, w_iss_row, w_iss_col};
  assign w_mem_idx   = w_full_addr[MemAddrWidth-1:0];
  assign w_out_v     = r_cl3 ? r_p2_v : r_p1_v;
  assign w_out_d     = r_cl3 ? r_p2_d : r_p1_d;

`ifdef SDRAM_TIMING_CHECK_EN
  logic [NUM_BANKS-1:0] w_rcd_ok, w_rp_ok, w_rc_ok;
  assign w_timing_err = (w_is_rw && !w_rcd_ok[i_bank]) ||
                        ((w_cmd == CMD_ACTIVE) && !w_rp_ok[i_bank]) ||
                        ((w_cmd != CMD_NOP) && !(&w_rc_ok));
`else
  assign w_timing_err = 1'b0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_act[b]    = (w_cmd == CMD_ACTIVE) && !w_sel_open && (i_bank == BankAddrLen'(b));
    assign w_pre[b]    = (w_cmd == CMD_PRECHARGE) && (w_pre_all || (i_bank == BankAddrLen'(b)));
    assign w_ap_req[b] = w_iss && w_iss_last && w_iss_ap && (w_iss_bank == BankAddrLen'(b));

    sdram_bank_state #(.RowAddrLen(RowAddrLen)) u_bank (
      .CLK         (CLK),
      .RST         (RST),
      .i_clk_en    (i_clk_en),
      .i_activate  (w_act[b]),
      .i_precharge (w_pre[b]),
      .i_ap_req    (w_ap_req[b]),
      .i_row       (i_addr),
`ifdef SDRAM_TIMING_CHECK_EN
      .i_refresh   (w_cmd == CMD_AUTO_REFRESH),
      .o_rcd_ok    (w_rcd_ok[b]),
      .o_rp_ok     (w_rp_ok[b]),
      .o_rc_ok     (w_rc_ok[b]),
`endif
      .o_open      (w_open[b]),
      .o_row       (w_bank_row[b])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bl_code    <= BL_CODE_RESET;
      r_cl3        <= 1'b0;
      r_bst_active <= 1'b0;
      r_bst_wr     <= 1'b0;
      r_bst_ap     <= 1'b0;
      r_bst_bank   <= '0;
      r_bst_row    <= '0;
      r_bst_base   <= '0;
      r_bst_idx    <= '0;
      r_p1_v       <= 1'b0;
      r_p1_d       <= '0;
      r_p2_v       <= 1'b0;
      r_p2_d       <= '0;
      o_dq         <= '0;
      o_dq_oe      <= 1'b0;
      o_proto_err  <= 1'b0;
    end else if (i_clk_en) begin
      o_proto_err <= w_proto_err || w_timing_err;
      if ((w_cmd == CMD_LOAD_MODE) && !w_proto_err) begin
        r_bl_code <= w_mode_bl[1:0];
        r_cl3     <= (w_mode_cl == CL_CODE_3);
      end

      if (w_rw_ok) begin
        r_bst_active <= !w_iss_last;
        r_bst_idx    <= 3'd1;
        r_bst_wr     <= w_iss_wr;
        r_bst_ap     <= w_iss_ap;
        r_bst_bank   <= w_iss_bank;
        r_bst_row    <= w_iss_row;
        r_bst_base   <= w_iss_base;
      end else if (w_iss) begin
        r_bst_active <= !w_iss_last;
        r_bst_idx    <= r_bst_idx + 3'd1;
      end else if (w_abort) begin
        r_bst_active <= 1'b0;
      end

      // A WRITE command discards any read data still in flight
      if (w_rw_ok && w_iss_wr) begin
        r_p1_v  <= 1'b0;
        r_p2_v  <= 1'b0;
        o_dq_oe <= 1'b0;
        o_dq    <= '0;
      end else begin
        r_p1_v  <= w_iss && !w_iss_wr;
        r_p1_d  <= r_mem[w_mem_idx];
        r_p2_v  <= r_p1_v;
        r_p2_d  <= r_p1_d;
        o_dq_oe <= w_out_v;
        o_dq    <= w_out_v ? w_out_d : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (i_clk_en && w_iss && w_iss_wr) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (!i_dqm[b]) r_mem[w_mem_idx][b*8 +: 8] <= i_dq[b*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire
